logic_sweep_ctrl: RTL and testbench

LOGIC_SWEEP_CTRL -- requirements
Module: logic_sweep_ctrl

---
 rtl/logic_sweep_ctrl_pkg.sv | 18 +
 rtl/logic_sweep_ctrl_if.sv | 31 +++
 rtl/logic_sweep_ctrl_popcount8.sv | 16 +
 rtl/logic_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared definitions for the truth-table sweep controller.
//   NVEC_DEF   : number of input vectors of a 3-input function (8)
//   SETTLE_DEF : default settle time, in cycles, per applied vector
//   state_e    : 3-bit encoding of the five sweep states
package logic_sweep_ctrl_pkg;

  localparam int NVEC_DEF   = 8;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Bundle of the sweep controller's request/response signals.
//   master : stimulus side (drives start, abort, expected and f_i)
//   slave  : controller side (drives x/y/z, busy, done and the verdict)
interface logic_sweep_ctrl_if;
  import logic_sweep_ctrl_pkg::*;

  logic                start;
  logic                abort;
  logic [NVEC_DEF-1:0] expected;
  logic                f_i;
  logic                x_o;
  logic                y_o;
  logic                z_o;
  logic                busy;
  logic                done;
  logic [NVEC_DEF-1:0] result;
  logic [NVEC_DEF-1:0] mismatch;
  logic [3:0]          err_count;
  logic                pass;

  modport master (
    output start, abort, expected, f_i,
    input  x_o, y_o, z_o, busy, done, result, mismatch, err_count, pass
  );

  modport slave (
    input  start, abort, expected, f_i,
    output x_o, y_o, z_o, busy, done, result, mismatch, err_count, pass
  );

endinterface

// File: rtl/logic_sweep_ctrl_popcount8.sv
// popcount8: combinational population count.
//   din : 8-bit input word
//   cnt : number of set bits in din (0..8)
module popcount8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(din[i]);
    end
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: walks an external 3-input combinational function through
// all eight input vectors, captures F for each one and compares the captured
// table with a golden table latched at start.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.start / bus.abort   : begin a sweep (IDLE only) / cancel a sweep
//   bus.expected            : golden truth table, latched on an accepted start
//   bus.f_i                 : F returned by the function under test
//   bus.x_o/y_o/z_o         : vector currently applied to the function
//   bus.busy / bus.done     : sweep in progress / one-cycle completion pulse
//   bus.result / bus.mismatch / bus.err_count / bus.pass : sweep verdict
module logic_sweep_ctrl
  import logic_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF,
  parameter int NVEC   = NVEC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_sweep_ctrl_if.slave   bus
);

  localparam logic [2:0] LAST_IDX    = 3'(NVEC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        settle_q, settle_d;
  logic [NVEC-1:0]   exp_q, exp_d;
  logic [NVEC-1:0]   result_q, result_d;
  logic [NVEC-1:0]   mismatch_q, mismatch_d;
  logic [3:0]        err_q, err_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;

  logic [NVEC-1:0]   diff_w;
  logic [3:0]        pop_w;

  assign diff_w = result_q ^ exp_q;

  popcount8 u_popcount8 (
    .din (diff_w),
    .cnt (pop_w)
  );

  // Next-state / datapath decisions
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    exp_d      = exp_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    pass_d     = pass_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort blocks a simultaneous start
        if (bus.start && !bus.abort) begin
          exp_d      = bus.expected;
          idx_d      = 3'd0;
          settle_d   = 4'd0;
          result_d   = '0;
          mismatch_d = '0;
          err_d      = 4'd0;
          pass_d     = 1'b0;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        result_d[idx_q] = bus.f_i;
        if (idx_q == LAST_IDX) begin
          state_d = ST_CHECK;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_APPLY;
        end
      end
      ST_CHECK: begin
        mismatch_d = diff_w;
        err_d      = pop_w;
        pass_d     = (diff_w == '0);
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        // done is registered, so the pulse lands in the cycle after DONE
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the whole sweep, including a pending done pulse
    if (bus.abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      idx_d      = 3'd0;
      settle_d   = 4'd0;
      result_d   = '0;
      mismatch_d = '0;
      err_d      = 4'd0;
      pass_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and verdict registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      settle_q   <= 4'd0;
      exp_q      <= '0;
      result_q   <= '0;
      mismatch_q <= '0;
      err_q      <= 4'd0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  // Vector is only presented while it is being settled or sampled
  always_comb begin
    {bus.x_o, bus.y_o, bus.z_o} = 3'b000;
    if (state_q == ST_APPLY || state_q == ST_SAMPLE) begin
      {bus.x_o, bus.y_o, bus.z_o} = idx_q;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
module tb_logic_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;        // 0: SETTLE=2 instance, 1: SETTLE=1 instance
  logic       start_r;
  logic       abort_r;
  logic [7:0] exp_r;
  int         mode;       // 0: F=x|y|z, 1: F stuck at 0, 2: F from table tt_r
  logic [7:0] tt_r;

  int n_assert = 0;
  int n_fail   = 0;

  logic_sweep_ctrl_if b2 ();
  logic_sweep_ctrl_if b1 ();

  logic_sweep_ctrl #(.SETTLE(2), .NVEC(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic_sweep_ctrl #(.SETTLE(1), .NVEC(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Function under test, evaluated on the applied vector {x,y,z}
  function automatic logic fut(input logic [2:0] v, input int m, input logic [7:0] t);
    case (m)
      0:       return v[2] | v[1] | v[0];
      1:       return 1'b0;
      default: return t[v];
    endcase
  endfunction

  assign b2.start    = start_r & ~sel;
  assign b1.start    = start_r & sel;
  assign b2.abort    = abort_r & ~sel;
  assign b1.abort    = abort_r & sel;
  assign b2.expected = exp_r;
  assign b1.expected = exp_r;
  assign b2.f_i      = fut({b2.x_o, b2.y_o, b2.z_o}, mode, tt_r);
  assign b1.f_i      = fut({b1.x_o, b1.y_o, b1.z_o}, mode, tt_r);

  logic       o_busy, o_done, o_pass;
  logic [2:0] o_xyz;
  logic [7:0] o_res, o_mis;
  logic [3:0] o_err;
  assign o_busy = sel ? b1.busy      : b2.busy;
  assign o_done = sel ? b1.done      : b2.done;
  assign o_pass = sel ? b1.pass      : b2.pass;
  assign o_xyz  = sel ? {b1.x_o, b1.y_o, b1.z_o} : {b2.x_o, b2.y_o, b2.z_o};
  assign o_res  = sel ? b1.result    : b2.result;
  assign o_mis  = sel ? b1.mismatch  : b2.mismatch;
  assign o_err  = sel ? b1.err_count : b2.err_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: truth table of the current function, bit v = F(vector v)
  function automatic logic [7:0] ref_tt();
    logic [7:0] t;
    for (int v = 0; v < 8; v++) t[v] = fut(3'(v), mode, tt_r);
    return t;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] w);
    logic [3:0] n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(w[i]);
    return n;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_xyz"},  o_xyz,  0);
    chk({tag, "_res"},  o_res,  0);
    chk({tag, "_mis"},  o_mis,  0);
    chk({tag, "_err"},  o_err,  0);
    chk({tag, "_pass"}, o_pass, 0);
  endtask

  // Count done pulses over n cycles with start idle; expect none and not busy
  task automatic quiet(input string tag, input int n);
    int pulses = 0;
    int busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_done) pulses++;
      if (o_busy) busy_seen++;
    end
    chk({tag, "_no_done"}, pulses, 0);
    chk({tag, "_idle"}, busy_seen, 0);
  endtask

  // Full sweep on the selected instance, checked against the reference
  task automatic sweep(input string tag, input logic [7:0] ex, input bit spam);
    int s;
    int lat;
    int c;
    logic [7:0] t;
    logic [7:0] mis;
    s   = sel ? 1 : 2;
    lat = 8 * (s + 1) + 2;
    t   = ref_tt();
    mis = t ^ ex;
    exp_r   = ex;
    start_r = 1'b1;
    tick();               // start sampled at this edge (k)
    start_r = 1'b0;
    exp_r   = ~ex;        // expected must have been latched
    c = 0;
    while (1) begin
      chk({tag, "_xyz"}, o_xyz, (c < 8 * (s + 1)) ? 3'(c / (s + 1)) : 3'd0);
      chk({tag, "_busy"}, o_busy, 1);
      if (spam) start_r = (c == lat - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      c++;
      if (o_done || c >= lat + 5) break;
    end
    start_r = 1'b0;
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy_end"}, o_busy, 0);
    chk({tag, "_res"}, o_res, t);
    chk({tag, "_mis"}, o_mis, mis);
    chk({tag, "_err"}, o_err, ones8(mis));
    chk({tag, "_pass"}, o_pass, (mis == 8'h00));
    tick();
    chk({tag, "_done_pulse"}, o_done, 0);
    chk({tag, "_no_restart"}, o_busy, 0);
    chk({tag, "_hold_res"}, o_res, t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    rst_n = 1'b0; sel = 1'b0; start_r = 1'b0; abort_r = 1'b0;
    exp_r = 8'h00; mode = 0; tt_r = 8'h00;
    repeat (3) tick();
    chk_reset_vals("rst2");
    sel = 1'b1; #1;
    chk_reset_vals("rst1");
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    // OR function, golden matches
    mode = 0;
    sweep("or_fe", 8'hFE, 1'b0);
    // OR function, golden differs at vector 0
    sweep("or_ff", 8'hFF, 1'b0);
    // F stuck at 0
    mode = 1;
    sweep("stuck0", 8'hFE, 1'b0);
    repeat (5) tick();
    chk("hold_mis", o_mis, 8'hFE);
    chk("hold_err", o_err, 7);

    // Abort during vector 4
    mode = 0;
    exp_r = 8'hFE; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (13) tick();
    chk("abort_pre_xyz", o_xyz, 3'd4);
    chk("abort_pre_res", o_res, ref_tt() & 8'h0F);
    abort_r = 1'b1;
    tick();
    abort_r = 1'b0;
    chk_reset_vals("abort");
    quiet("abort", 40);

    // abort and start together in IDLE
    start_r = 1'b1; abort_r = 1'b1;
    tick();
    start_r = 1'b0; abort_r = 1'b0;
    chk("abort_start_busy", o_busy, 0);
    quiet("abort_start", 5);

    // start hammered while busy
    sweep("spam", 8'hFE, 1'b1);
    quiet("spam", 30);

    // Random functions and golden tables
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      tt_r = 8'($urandom);
      sweep("rand2", (i == 0) ? tt_r : 8'($urandom), 1'b0);
    end

    // SETTLE=1 instance: reset during vector 6, then a clean sweep
    sel = 1'b1; mode = 0; #1;
    exp_r = 8'hFE; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    repeat (12) tick();
    chk("rst_mid_xyz", o_xyz, 3'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("rst_mid");
    quiet("rst_mid", 30);
    sweep("s1_or", 8'hFE, 1'b0);
    mode = 2;
    for (int i = 0; i < 2; i++) begin
      tt_r = 8'($urandom);
      sweep("rand1", 8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
